// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small input FIFO; queued bytes go out back-to-back.
// The line is driven from a flop that is loaded with the next bit value on each state change.
module uart_tx #(
    parameter logic [9:0]  DIV_CNT = 10'd867,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_vld,
    input  logic [7:0] tx_data,
    output logic       tx_rdy,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e             state;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [9:0]         div_cnt;
    logic [2:0]         bit_cnt;
    logic [7:0]         shift;

    logic div_end;
    logic fifo_nonempty;
    logic push;
    logic pop;

    assign div_end       = (div_cnt == DIV_CNT);
    assign fifo_nonempty = (count != '0);
    assign tx_rdy        = (count != FULL);
    assign push          = tx_vld && tx_rdy;
    // The FSM only pops from IDLE or on the final stop-bit cycle.
    assign pop           = fifo_nonempty && ((state == StIdle) || ((state == StStop) && div_end));
    assign tx_busy       = (state != StIdle) || fifo_nonempty;
    assign tx_done       = (state == StStop) && div_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            tx      <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            case (state)
                StIdle: begin
                    div_cnt <= '0;
                    tx      <= 1'b1;
                    if (fifo_nonempty) begin
                        shift   <= mem[rd_ptr];
                        bit_cnt <= '0;
                        tx      <= 1'b0;
                        state   <= StStart;
                    end
                end
                StStart: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        tx      <= shift[0];
                        state   <= StData;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                StData: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        shift   <= {1'b0, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= StStop;
                        end else begin
                            tx <= shift[1];
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                StStop: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        if (fifo_nonempty) begin
                            shift   <= mem[rd_ptr];
                            bit_cnt <= '0;
                            tx      <= 1'b0;
                            state   <= StStart;
                        end else begin
                            state <= StIdle;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serialises bytes onto the `tx` line in 8N1 format (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) at the same bit period as the team's UART receiver. It is the PDU's outbound serial path. Bytes are accepted over a valid/ready handshake into a small FIFO, so the producer can queue several bytes and frames go out back-to-back with no idle gap.

## Interface
- `DIV_CNT`, default 10'd867: bit period is DIV_CNT+1 = 868 clk cycles (100 MHz → 115200 baud).
- `FIFO_AW`, default 2: FIFO address width; depth = 2^FIFO_AW = 4 entries.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `tx_vld`  in  1  producer has a byte on `tx_data`.
- `tx_data`  in  8  byte to send; sampled when `tx_vld && tx_rdy`.
- `tx_rdy`  out  1  FIFO can accept a byte (count < depth).
- `tx`  out  1  serial line, registered, idles high.
- `tx_busy`  out  1  FIFO non-empty or a frame in progress.
- `tx_done`  out  1  one-cycle pulse on the last cycle of each stop bit.

## Operation
- FIFO: `wr_ptr`/`rd_ptr` of FIFO_AW bits plus a FIFO_AW+1-bit `count`. Pointers wrap modulo depth. Push on `tx_vld && tx_rdy`. Pop is issued by the FSM only.
- Simultaneous push and pop: `count` unchanged, both pointers advance. When full, `tx_rdy`=0 even if a pop occurs in the same cycle (no bypass). A push while `tx_rdy`=0 is ignored, and the FIFO contents are not modified.
- `tx_rdy` = (count != depth), combinational from registered `count`.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If count≠0: pop the FIFO head into the 8-bit shift register, clear `div_cnt` and `bit_cnt`, go to START.
  - START: `tx`=0 for DIV_CNT+1 cycles. At `div_cnt==DIV_CNT`, go to DATA.
  - DATA: `tx`=shift[0]. At `div_cnt==DIV_CNT`: shift right by 1 and increment `bit_cnt`. After the 8th bit (`bit_cnt==7` at terminal count), go to STOP.
  - STOP: `tx`=1 for DIV_CNT+1 cycles. At terminal count, pulse `tx_done`. If count≠0, pop the next byte in that same cycle and go directly to START; otherwise go to IDLE.
- `div_cnt` (10 bits) counts 0..DIV_CNT, then wraps to 0. It is held at 0 in IDLE.
- `tx` is driven from a flop, not from combinational FSM decode.
- `tx_busy` = (state≠IDLE) || (count≠0).

## Timing
- Reset values: `tx`=1, `tx_rdy`=1, `tx_busy`=0, `tx_done`=0. FSM in IDLE, FIFO empty, all counters 0.
- Reset asserted mid-frame: `tx` returns to 1 immediately (asynchronous), FIFO contents are discarded, and no `tx_done` is issued. After reset release, the line stays high until a new push.
- Latency: byte pushed at edge E into an empty FIFO with the FSM in IDLE → at edge E+1 the byte is popped and `tx` falls. Start bit occupies E+1 .. E+868.
- Frame length: exactly 10×868 = 8680 cycles from `tx` falling to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle, with zero idle cycles.
- `tx_done` is high for exactly one cycle per frame, coincident with the final stop-bit cycle.
- A pop frees a slot visible on `tx_rdy` in the following cycle.

## Test plan
- Single byte: push 0x55 while idle → `tx` falls 1 cycle later. Line reads 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each bit 868 cycles. One `tx_done` pulse, then `tx_busy`=0.
- Back-to-back: push 0xA3, 0x00, 0xFF on consecutive cycles → three frames totalling 26040 cycles with no idle gap, exactly three `tx_done` pulses, and correct bit patterns for all-zero and all-one data.
- FIFO full: push 6 bytes 0x10..0x15 continuously while `tx_vld`=1. First pushes accepted; `tx_rdy` drops once the count reaches 4. 0x10..0x14 are transmitted (one popped immediately, so 5 accepted). Bytes offered while `tx_rdy`=0 are not transmitted.
- Simultaneous push/pop at full: hold `tx_vld` high through a STOP→START pop → `count` stays correct and byte order is preserved.
- Reset mid-frame: assert `rst` during DATA bit 3 of 0xC7 with 2 bytes queued → `tx`=1 immediately, `tx_rdy`=1, `tx_busy`=0. After release, nothing is transmitted until a new push.
- Loopback: connect `tx` to the team's UART receiver, push 16 random bytes → the receiver reports each byte in order with matching data.
